// File: rtl/fifo_wr_arb_if.sv
// Write-port bus between N requesters, the round-robin arbiter and a synchronous FIFO.
// Handshake: req[i] is requester i's valid, fifo_full is the FIFO's not-ready, and a beat
// transfers in exactly the cycle ack[i] (equivalently fifo_wr) is high.
interface fifo_wr_arb_if #(
    parameter int W = 8,
    parameter int N = 4
);
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic           fifo_full;
    logic           fifo_wr;
    logic [W-1:0]   fifo_wr_data;
    logic [N-1:0]   grant;
    logic [N-1:0]   ack;
    logic           busy;

    modport master (
        input  req, req_data, fifo_full,
        output fifo_wr, fifo_wr_data, grant, ack, busy
    );

    modport slave (
        output req, req_data, fifo_full,
        input  fifo_wr, fifo_wr_data, grant, ack, busy
    );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter for one FIFO write port; an owner keeps the port for up to BURST beats.
// Define FIFO_ARB_STATS_EN to add the saturating stall_cnt output.
module fifo_wr_arb #(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    fifo_wr_arb_if.master bus,
    output logic          state_dbg
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(BURST) + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);
    localparam logic [N-1:0]  ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state, state_nx;
    logic [N-1:0]    grant_q, grant_nx;
    logic [IW-1:0]   owner_q, owner_nx;
    logic [IW-1:0]   last_q, last_nx;
    logic [CW-1:0]   beat_q, beat_nx;
    logic            busy;
    logic            owner_req;
    logic            wr;
    logic [IW:0]     pick_res;

    // Returns {found, index}: first requester above l, wrapping modulo N, ending at l itself.
    function automatic logic [IW:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] l);
        logic [IW:0]   res;
        logic [IW-1:0] c;
        res = '0;
        for (int k = N; k >= 1; k--) begin
            c = IW'((int'(l) + k) % N);
            if (r[c]) res = {1'b1, c};
        end
        return res;
    endfunction

    assign pick_res  = rr_pick(bus.req, last_q);
    assign state_dbg = state;

    always_comb begin
        busy             = (state == GRANT);
        owner_req        = bus.req[owner_q];
        wr               = busy & owner_req & ~bus.fifo_full;
        bus.fifo_wr      = wr;
        bus.ack          = wr ? grant_q : '0;
        bus.fifo_wr_data = busy ? bus.req_data[owner_q*W +: W] : '0;
        bus.grant        = grant_q;
        bus.busy         = busy;
    end

    always_comb begin
        state_nx = state;
        grant_nx = grant_q;
        owner_nx = owner_q;
        last_nx  = last_q;
        beat_nx  = beat_q;
        case (state)
            IDLE: begin
                if (pick_res[IW]) begin
                    state_nx = GRANT;
                    owner_nx = pick_res[IW-1:0];
                    grant_nx = ONE_HOT0 << pick_res[IW-1:0];
                    beat_nx  = '0;
                end
            end
            GRANT: begin
                if (wr) beat_nx = beat_q + 1'b1;
                // Release on the final beat of the burst or as soon as the owner stops requesting.
                if ((wr && (beat_q == LAST_BEAT)) || !owner_req) begin
                    state_nx = IDLE;
                    grant_nx = '0;
                    last_nx  = owner_q;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= IW'(N - 1);
            beat_q  <= '0;
        end else begin
            state   <= state_nx;
            grant_q <= grant_nx;
            owner_q <= owner_nx;
            last_q  <= last_nx;
            beat_q  <= beat_nx;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (busy && owner_req && bus.fifo_full && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed scenarios plus random traffic against a behavioural model,
// with a separate monitor scoring every FIFO write against the expected queue.
module tb_fifo_wr_arb;
    localparam int W     = 8;
    localparam int N     = 4;
    localparam int BURST = 4;

    logic clk;
    logic rst;
    logic state_dbg;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0] stall_cnt;
`endif

    fifo_wr_arb_if #(.W(W), .N(N)) bus ();

    fifo_wr_arb #(.W(W), .N(N), .BURST(BURST)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int           m_owner;
    int           m_last;
    int           m_beats;
    logic [15:0]  m_stall;
    logic [W-1:0] next_data [N];
    logic [N-1:0] prev_grant;

    logic [W-1:0] exp_q [$];
    logic [W-1:0] wr_log [$];
    int           grant_log [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner    = -1;
        m_last     = N - 1;
        m_beats    = 0;
        m_stall    = '0;
        prev_grant = '0;
    endtask

    task automatic apply(input logic [N-1:0] r, input logic full);
        bus.req       = r;
        bus.fifo_full = full;
        for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = next_data[i];
    endtask

    // One cycle: drive at the falling edge, check outputs, predict, advance the model.
    task automatic step(input logic [N-1:0] r, input logic full);
        logic         busy_e;
        logic         wr_e;
        logic [N-1:0] grant_e;
        logic [N-1:0] one;
        logic [W-1:0] data_e;
        one = 1;
        apply(r, full);
        #1;
        busy_e  = (m_owner >= 0);
        grant_e = busy_e ? (one << m_owner) : '0;
        wr_e    = busy_e && r[m_owner] && !full;
        data_e  = busy_e ? next_data[m_owner] : '0;
        check("grant", bus.grant, grant_e);
        check("busy", bus.busy, busy_e);
        check("state_dbg", state_dbg, busy_e);
        check("fifo_wr", bus.fifo_wr, wr_e);
        check("ack", bus.ack, wr_e ? grant_e : '0);
        check("fifo_wr_data", bus.fifo_wr_data, data_e);
`ifdef FIFO_ARB_STATS_EN
        check("stall_cnt", stall_cnt, m_stall);
`endif
        if (prev_grant == '0 && bus.grant != '0) begin
            for (int i = 0; i < N; i++) if (bus.grant[i]) grant_log.push_back(i);
        end
        prev_grant = bus.grant;
        if (wr_e) exp_q.push_back(next_data[m_owner]);
        if (busy_e) begin
            if (r[m_owner] && full && m_stall != 16'hFFFF) m_stall++;
            if (wr_e) begin
                m_beats++;
                next_data[m_owner]++;
            end
            if ((wr_e && m_beats == BURST) || !r[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end else if (r != '0) begin
            for (int k = N; k >= 1; k--) if (r[(m_last + k) % N]) m_owner = (m_last + k) % N;
            m_beats = 0;
        end
        @(negedge clk);
    endtask

    // Asynchronous reset pulse landing between edges, released at the next falling edge.
    task automatic rst_pulse(input logic [N-1:0] r);
        apply(r, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_grant", bus.grant, '0);
        check("rst_fifo_wr", bus.fifo_wr, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_ack", bus.ack, '0);
        check("rst_data", bus.fifo_wr_data, '0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // monitor / scoreboard: sample just before each rising edge
    initial begin
        forever begin
            @(negedge clk);
            #4;
            check("wr_while_full", bus.fifo_wr & bus.fifo_full, 1'b0);
            if (bus.fifo_wr) begin
                wr_log.push_back(bus.fifo_wr_data);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1'b1, 1'b0);
                end else begin
                    check("fifo_data", bus.fifo_wr_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [N-1:0] cur_req;
        rst = 1'b1;
        for (int i = 0; i < N; i++) next_data[i] = W'(8'h40 + 16 * i);
        apply('0, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_grant", bus.grant, '0);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_fifo_wr", bus.fifo_wr, 1'b0);
        check("reset_ack", bus.ack, '0);
`ifdef FIFO_ARB_STATS_EN
        check("reset_stall_cnt", stall_cnt, '0);
`endif
        rst = 1'b0;

        // single requester, 6 beats: burst of 4, one idle cycle, then 2 more
        next_data[0] = 8'h10;
        for (int c = 0; c < 8; c++) step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        check("s1_write_count", wr_log.size(), 6);
        if (wr_log.size() >= 6) begin
            for (int i = 0; i < 6; i++) check("s1_write_order", wr_log[i], W'(8'h10 + i));
        end

        // all requesting: owners 0,1,2,3,0
        rst_pulse(4'b0000);
        grant_log.delete();
        for (int c = 0; c < 25; c++) step(4'b1111, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        check("s2_grants", grant_log.size(), 5);
        if (grant_log.size() >= 5) begin
            check("s2_g0", grant_log[0], 0);
            check("s2_g1", grant_log[1], 1);
            check("s2_g2", grant_log[2], 2);
            check("s2_g3", grant_log[3], 3);
            check("s2_g4", grant_log[4], 0);
        end

        // owner 2 drops after 2 beats; requester 3 follows
        grant_log.delete();
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b1000, 1'b0);
        step(4'b1000, 1'b0);
        step(4'b1000, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        check("s3_grants", grant_log.size(), 2);
        if (grant_log.size() >= 2) begin
            check("s3_first", grant_log[0], 2);
            check("s3_second", grant_log[1], 3);
        end

        // FIFO full for 3 cycles mid-burst
        base = wr_log.size();
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        for (int c = 0; c < 3; c++) step(4'b0001, 1'b1);
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
        check("s4_beats", wr_log.size() - base, 4);
`ifdef FIFO_ARB_STATS_EN
        check("s4_stall_cnt", stall_cnt, 16'd3);
`endif

        // reset during beat 2, then requester 0 wins first
        grant_log.delete();
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        rst_pulse(4'b1111);
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);
        check("s5_regrant", grant_log.size(), 2);
        if (grant_log.size() >= 2) check("s5_owner", grant_log[1], 0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);

        // random traffic with sticky requests and random back-pressure
        for (int i = 0; i < N; i++) next_data[i] = W'($urandom_range(0, 255));
        cur_req = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) cur_req[i] = ~cur_req[i];
            step(cur_req, ($urandom_range(0, 3) == 0));
        end
        for (int c = 0; c < 3; c++) step(4'b0000, 1'b0);
        check("exp_q_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
- REQ-001 Parameter W, default 8: data width in bits per requester and for the FIFO write port.
- REQ-002 Parameter N, default 4: number of requesters, 2..8.
- REQ-003 Parameter BURST, default 4: maximum accepted beats per grant, 1..16.
- REQ-004 clk  in  1: single clock; all state updates on the rising edge.
- REQ-005 rst  in  1: asynchronous, active-high reset.
- REQ-006 req  in  N: bit i high means requester i has a beat to write.
- REQ-007 req_data  in  N*W: requester i data in bits [i*W +: W].
- REQ-008 fifo_full  in  1: full flag from the synchronous FIFO.
- REQ-009 fifo_wr  out  1: write strobe to the FIFO.
- REQ-010 fifo_wr_data  out  W: write data to the FIFO.
- REQ-011 grant  out  N: one-hot owner of the write port, registered; all zero when idle.
- REQ-012 ack  out  N: one-hot, high in the cycle that requester's beat is written.
- REQ-013 busy  out  1: high in the GRANT state.

Function
- REQ-014 FSM has two states, IDLE and GRANT.
- REQ-015 IDLE with any req bit set: choose the owner round-robin, searching upward from last+1 modulo N; load grant; clear beat_cnt; go to GRANT.
- REQ-016 IDLE with req all zero: remain in IDLE; grant stays 0.
- REQ-017 Write path is combinational from registered state: fifo_wr = busy & req[owner] & !fifo_full.
- REQ-018 ack = grant when fifo_wr is high, else 0.
- REQ-019 fifo_wr_data = owner's req_data slice in GRANT, else 0.
- REQ-020 Latency: a req first seen in IDLE at edge t gets grant after edge t; the first beat can be written in the same cycle grant is high.
- REQ-021 Each accepted beat increments beat_cnt; beat_cnt width is clog2(BURST)+1.
- REQ-022 Release to IDLE at the next edge on either condition: (a) an accept occurs with beat_cnt == BURST-1, or (b) req[owner] is low. On release, last <= owner.
- REQ-023 Cycles with fifo_full high while in GRANT: no write, no ack, beat_cnt unchanged, grant held.
- REQ-024 IDLE always lasts at least one cycle between grants (arbitration cycle).
- REQ-025 Fairness: a requester holding req high is granted within N grants.
- REQ-026 Requests from non-owner requesters are ignored during GRANT; their ack stays 0.
- REQ-027 fifo_wr shall never be high while fifo_full is high.

Reset
- REQ-028 On rst asserted, immediately and without a clock: state=IDLE, grant=0, beat_cnt=0, last=N-1, so requester 0 has first priority.
- REQ-029 Because fifo_wr, ack, fifo_wr_data and busy decode from state, they are 0 during reset.
- REQ-030 Reset asserted mid-burst aborts the burst with no further write; beats already written are not undone.
- REQ-031 Deassertion is synchronous to clk; first grant possible at the first edge after deassertion.

Configuration
- REQ-032 With macro FIFO_ARB_STATS_EN defined: output stall_cnt [15:0] counts cycles where busy & req[owner] & fifo_full, saturates at 16'hFFFF, and resets to 0.
- REQ-033 Without FIFO_ARB_STATS_EN: the stall_cnt port and its counter are absent; all other behaviour is identical.

Verification (N=4, BURST=4, W=8)
- REQ-034 After reset, req=4'b0001 with data 8'h10..8'h15 held → grant=0001, writes 10,11,12,13 on 4 consecutive cycles, then 1 IDLE cycle, then re-grant to 0 for 14,15.
- REQ-035 req=4'b1111 held → grant order 0,1,2,3,0 with 4 beats each and one IDLE cycle between grants.
- REQ-036 Owner 2 drops req after 2 beats → release next edge; next grant goes to requester 3 if requesting.
- REQ-037 fifo_full high for 3 cycles mid-burst → fifo_wr=0 and ack=0 for those cycles, burst resumes with beat_cnt preserved, 4 beats total; with FIFO_ARB_STATS_EN, stall_cnt=3.
- REQ-038 rst pulsed asynchronously between edges during beat 2 → grant=0 and fifo_wr=0 immediately; after release, requester 0 is granted first.
- REQ-039 Scoreboard across all scenarios: FIFO contents equal the concatenation of acked beats in order, and there is no write while fifo_full is high.
